// File: rtl/barril_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// barril_pkg: shared colour-index, palette and roll-phase types.  Rev 1.0
// ---------------------------------------------------------------------------
package barril_pkg;

    typedef logic [1:0] color_idx_t;

    localparam color_idx_t IDX_TRANSPARENT = 2'b00;
    localparam color_idx_t IDX_BODY        = 2'b01;
    localparam color_idx_t IDX_RIM         = 2'b10;
    localparam color_idx_t IDX_BAND        = 2'b11;

    localparam logic [23:0] RGB_NONE = 24'h000000;
    localparam logic [23:0] RGB_BODY = 24'h8B4513;
    localparam logic [23:0] RGB_RIM  = 24'hFF8C00;
    localparam logic [23:0] RGB_BAND = 24'h4A2810;

    typedef enum logic [1:0] {
        ROLL_0  = 2'd0,
        ROLL_H  = 2'd1,
        ROLL_HV = 2'd2,
        ROLL_V  = 2'd3
    } roll_phase_t;

    function automatic logic [23:0] palette(input color_idx_t idx);
        logic [23:0] rgb;
        case (idx)
            IDX_BODY: rgb = RGB_BODY;
            IDX_RIM:  rgb = RGB_RIM;
            IDX_BAND: rgb = RGB_BAND;
            default:  rgb = RGB_NONE;
        endcase
        return rgb;
    endfunction

endpackage
`default_nettype wire

// File: rtl/barril_roll_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// barril_roll_ctrl: per-frame counter and rolling mirror phase.  Rev 1.0
// ---------------------------------------------------------------------------
module barril_roll_ctrl
    import barril_pkg::*;
#(
    parameter int ROLL_FRAMES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic frame_start,
    input  logic roll_en,
    output logic h_mirror,
    output logic v_mirror
);

    localparam logic [7:0] WRAP_AT = 8'(ROLL_FRAMES - 1);

    roll_phase_t phase, phase_next;
    logic [7:0]  frame_cnt, frame_cnt_next;
    logic [7:0]  frame_cnt_inc;

    always_ff @(posedge clk) begin
        if (reset) begin
            phase     <= ROLL_0;
            frame_cnt <= 8'd0;
        end else begin
            phase     <= phase_next;
            frame_cnt <= frame_cnt_next;
        end
    end

    always_comb begin
        phase_next     = phase;
        frame_cnt_next = frame_cnt;
        frame_cnt_inc  = frame_cnt + 8'd1;
        h_mirror       = 1'b0;
        v_mirror       = 1'b0;

        // ">=" also covers ROLL_FRAMES == 1, where every frame advances the phase
        if (frame_start && roll_en) begin
            if (frame_cnt_inc >= WRAP_AT) begin
                frame_cnt_next = 8'd0;
                case (phase)
                    ROLL_0:  phase_next = ROLL_H;
                    ROLL_H:  phase_next = ROLL_HV;
                    ROLL_HV: phase_next = ROLL_V;
                    default: phase_next = ROLL_0;
                endcase
            end else begin
                frame_cnt_next = frame_cnt_inc;
            end
        end

        case (phase)
            ROLL_H:  h_mirror = 1'b1;
            ROLL_HV: begin
                h_mirror = 1'b1;
                v_mirror = 1'b1;
            end
            ROLL_V:  v_mirror = 1'b1;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/barril_sprite_renderer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// barril_sprite_renderer: barrel sprite address generator and RGB stage.  Rev 1.0
// ---------------------------------------------------------------------------
module barril_sprite_renderer
    import barril_pkg::*;
#(
    parameter int SPRITE_W    = 9,
    parameter int SPRITE_H    = 10,
    parameter int ROLL_FRAMES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic [9:0]  pos_x,
    input  logic [9:0]  pos_y,
    input  logic        pos_valid,
    output logic        pos_ready,
    input  logic        roll_en,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic        pix_en,
    output logic [9:0]  spr_horz,
    output logic [9:0]  spr_vert,
    input  logic [1:0]  spr_idx,
    output logic        pixel_valid,
    output logic [23:0] pixel_rgb
);

    localparam logic [9:0] SPR_W = 10'(SPRITE_W);
    localparam logic [9:0] SPR_H = 10'(SPRITE_H);

    logic [9:0] act_x, act_y;
    logic [9:0] pend_x, pend_y;
    logic       pend_full;
    logic       h_mirror, v_mirror;
    logic [9:0] dx, dy, col, row;
    logic       hit0, hit1;
    logic       opaque;

    assign pos_ready = !pend_full;

    // Active position only moves at frame_start so a frame is never torn.
    always_ff @(posedge clk) begin
        if (reset) begin
            act_x     <= 10'd0;
            act_y     <= 10'd0;
            pend_x    <= 10'd0;
            pend_y    <= 10'd0;
            pend_full <= 1'b0;
        end else begin
            if (frame_start && pend_full) begin
                act_x     <= pend_x;
                act_y     <= pend_y;
                pend_full <= 1'b0;
            end
            if (pos_valid && !pend_full) begin
                pend_x    <= pos_x;
                pend_y    <= pos_y;
                pend_full <= 1'b1;
            end
        end
    end

    barril_roll_ctrl #(
        .ROLL_FRAMES (ROLL_FRAMES)
    ) u_roll_ctrl (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .roll_en     (roll_en),
        .h_mirror    (h_mirror),
        .v_mirror    (v_mirror)
    );

    // Modular subtraction: pixels left of / above the sprite wrap to large values.
    always_comb begin
        dx   = pix_x - act_x;
        dy   = pix_y - act_y;
        hit0 = pix_en && (dx < SPR_W) && (dy < SPR_H);
        col  = h_mirror ? (SPR_W - 10'd1 - dx) : dx;
        row  = v_mirror ? (SPR_H - 10'd1 - dy) : dy;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            spr_horz <= 10'd0;
            spr_vert <= 10'd0;
            hit1     <= 1'b0;
        end else begin
            spr_horz <= hit0 ? col : 10'd0;
            spr_vert <= hit0 ? row : 10'd0;
            hit1     <= hit0;
        end
    end

    assign opaque = hit1 && (spr_idx != IDX_TRANSPARENT);

    always_ff @(posedge clk) begin
        if (reset) begin
            pixel_valid <= 1'b0;
            pixel_rgb   <= RGB_NONE;
        end else begin
            pixel_valid <= opaque;
            pixel_rgb   <= opaque ? palette(spr_idx) : RGB_NONE;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_barril_sprite_renderer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_barril_sprite_renderer: scoreboard bench for the barrel sprite renderer.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_barril_sprite_renderer;

    localparam int RF = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_start = 1'b0;
    logic [9:0]  pos_x = 10'd0, pos_y = 10'd0;
    logic        pos_valid = 1'b0;
    logic        pos_ready;
    logic        roll_en = 1'b0;
    logic [9:0]  pix_x = 10'd0, pix_y = 10'd0;
    logic        pix_en = 1'b0;
    logic [9:0]  spr_horz, spr_vert;
    logic [1:0]  spr_idx;
    logic        pixel_valid;
    logic [23:0] pixel_rgb;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [9:0] h;
        logic [9:0] v;
        logic       hit;
    } addr_exp_t;

    typedef struct {
        logic        valid;
        logic [23:0] rgb;
    } pix_exp_t;

    addr_exp_t addr_q[$];
    pix_exp_t  pix_q[$];

    // reference state
    logic [9:0] m_ax, m_ay, m_px, m_py;
    logic       m_full;
    int         m_cnt, m_phase;

    barril_sprite_renderer #(
        .SPRITE_W    (9),
        .SPRITE_H    (10),
        .ROLL_FRAMES (RF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .pos_valid   (pos_valid),
        .pos_ready   (pos_ready),
        .roll_en     (roll_en),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_en      (pix_en),
        .spr_horz    (spr_horz),
        .spr_vert    (spr_vert),
        .spr_idx     (spr_idx),
        .pixel_valid (pixel_valid),
        .pixel_rgb   (pixel_rgb)
    );

    always #5 clk = ~clk;

    // Sprite memory stand-in: (row+col+3) mod 4, so (3,0) -> 2 and (0,1) -> 0.
    function automatic logic [1:0] mem_idx(input logic [9:0] v, input logic [9:0] h);
        logic [11:0] s;
        s = {2'b00, v} + {2'b00, h} + 12'd3;
        return s[1:0];
    endfunction

    assign spr_idx = mem_idx(spr_vert, spr_horz);

    function automatic logic [23:0] ref_rgb(input logic [1:0] idx);
        case (idx)
            2'b01:   return 24'h8B4513;
            2'b10:   return 24'hFF8C00;
            2'b11:   return 24'h4A2810;
            default: return 24'h000000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_ax = 10'd0; m_ay = 10'd0; m_px = 10'd0; m_py = 10'd0;
        m_full = 1'b0; m_cnt = 0; m_phase = 0;
        addr_q.delete();
        pix_q.delete();
    endtask

    // One clock: check matured outputs, drive inputs, queue expectations, step model.
    task automatic cyc(input logic fs, input logic roll, input logic pv,
                       input logic [9:0] px, input logic [9:0] py,
                       input logic [9:0] x, input logic [9:0] y, input logic en);
        addr_exp_t a;
        pix_exp_t  p;
        logic [9:0] dx, dy;
        logic hm, vm, apply, cap;
        logic [1:0] idx;
        @(negedge clk);
        if (pix_q.size() > 0) begin
            p = pix_q.pop_front();
            check("pixel_valid", {31'd0, pixel_valid}, {31'd0, p.valid});
            check("pixel_rgb", {8'd0, pixel_rgb}, {8'd0, p.rgb});
        end
        if (addr_q.size() > 0) begin
            a = addr_q.pop_front();
            check("spr_horz", {22'd0, spr_horz}, {22'd0, a.h});
            check("spr_vert", {22'd0, spr_vert}, {22'd0, a.v});
            idx = mem_idx(a.v, a.h);
            p.valid = a.hit && (idx != 2'b00);
            p.rgb   = p.valid ? ref_rgb(idx) : 24'h0;
            pix_q.push_back(p);
        end
        check("pos_ready", {31'd0, pos_ready}, {31'd0, !m_full});

        frame_start = fs; roll_en = roll; pos_valid = pv;
        pos_x = px; pos_y = py; pix_x = x; pix_y = y; pix_en = en;

        dx = x - m_ax;
        dy = y - m_ay;
        hm = (m_phase == 1) || (m_phase == 2);
        vm = (m_phase == 2) || (m_phase == 3);
        a.hit = en && (dx < 10'd9) && (dy < 10'd10);
        a.h   = a.hit ? (hm ? 10'd8 - dx : dx) : 10'd0;
        a.v   = a.hit ? (vm ? 10'd9 - dy : dy) : 10'd0;
        addr_q.push_back(a);

        apply = fs && m_full;
        cap   = pv && !m_full;
        if (apply) begin
            m_ax = m_px; m_ay = m_py; m_full = 1'b0;
        end
        if (cap) begin
            m_px = px; m_py = py; m_full = 1'b1;
        end
        if (fs && roll) begin
            if (m_cnt + 1 >= RF - 1) begin
                m_cnt = 0;
                m_phase = (m_phase + 1) % 4;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 10'd0, 10'd0, 1'b0);
    endtask

    task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic en);
        cyc(1'b0, 1'b0, 1'b0, 10'd0, 10'd0, x, y, en);
    endtask

    task automatic frame(input logic roll);
        cyc(1'b1, roll, 1'b0, 10'd0, 10'd0, 10'd0, 10'd0, 1'b0);
    endtask

    task automatic submit(input logic [9:0] x, input logic [9:0] y);
        cyc(1'b0, 1'b0, 1'b1, x, y, 10'd0, 10'd0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        frame_start = 1'b0; pos_valid = 1'b0; roll_en = 1'b0; pix_en = 1'b0;
        @(negedge clk);
        check("rst_horz", {22'd0, spr_horz}, 32'd0);
        check("rst_vert", {22'd0, spr_vert}, 32'd0);
        check("rst_valid", {31'd0, pixel_valid}, 32'd0);
        check("rst_rgb", {8'd0, pixel_rgb}, 32'd0);
        check("rst_ready", {31'd0, pos_ready}, 32'd1);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic drain();
        repeat (3) idle();
    endtask

    initial begin
        model_clear();
        do_reset();

        // handshake and basic lookups
        submit(10'd100, 10'd50);
        idle();
        frame(1'b0);
        pix(10'd100, 10'd53, 1'b1);
        pix(10'd99,  10'd50, 1'b1);
        pix(10'd109, 10'd50, 1'b1);
        pix(10'd108, 10'd59, 1'b1);
        pix(10'd101, 10'd50, 1'b1);
        pix(10'd104, 10'd55, 1'b0);
        pix(10'd100, 10'd49, 1'b1);
        pix(10'd104, 10'd55, 1'b1);
        drain();

        // rolling phases
        repeat (7) frame(1'b1);
        pix(10'd100, 10'd50, 1'b1);
        pix(10'd102, 10'd53, 1'b1);
        repeat (7) frame(1'b1);
        pix(10'd100, 10'd50, 1'b1);
        repeat (7) frame(1'b1);
        pix(10'd100, 10'd50, 1'b1);
        repeat (7) frame(1'b1);
        pix(10'd100, 10'd50, 1'b1);
        repeat (3) frame(1'b0);
        pix(10'd105, 10'd52, 1'b1);
        drain();

        // mid-frame position change, second request ignored
        submit(10'd200, 10'd60);
        pix(10'd100, 10'd50, 1'b1);
        pix(10'd200, 10'd60, 1'b1);
        submit(10'd300, 10'd70);
        frame(1'b0);
        pix(10'd200, 10'd60, 1'b1);
        pix(10'd100, 10'd50, 1'b1);
        frame(1'b0);
        pix(10'd203, 10'd64, 1'b1);
        pix(10'd300, 10'd70, 1'b1);
        drain();

        // screen-edge wrap
        submit(10'd1020, 10'd1018);
        frame(1'b0);
        pix(10'd1023, 10'd1020, 1'b1);
        pix(10'd2,    10'd1020, 1'b1);
        pix(10'd5,    10'd1020, 1'b1);
        pix(10'd1021, 10'd3,    1'b1);
        drain();

        // reset with pending update and phase 2
        repeat (14) frame(1'b1);
        submit(10'd400, 10'd100);
        idle();
        do_reset();
        frame(1'b0);
        pix(10'd0,   10'd0,   1'b1);
        pix(10'd8,   10'd2,   1'b1);
        pix(10'd400, 10'd100, 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
